// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Owns the program counter,
//               fetches one word per cycle from a combinational instruction
//               memory into a single IF/ID buffer, honours decode back-pressure,
//               takes redirects from execute and stops on a halt word.
//               Optional macro FETCH_ALIGN_CHECK_EN: a redirect to a
//               non-word-aligned target raises a sticky misalign_err and halts
//               instead of being silently aligned down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [7:0]  if_pc,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [7:0]  r_if_pc;
  logic        r_halted;

  logic [7:0]  w_redirect_pc;
  logic        w_misaligned;
  logic        w_capture;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_misalign_err;

  // Target is used verbatim; a misaligned one is rejected rather than fixed up.
  assign w_redirect_pc = br_target;
  assign w_misaligned  = |br_target[1:0];
  assign misalign_err  = r_misalign_err;
`else
  logic        w_unused_tgt_lsbs;

  // Low address bits are dropped so every redirect lands on a word boundary.
  assign w_redirect_pc     = {br_target[7:2], 2'b00};
  assign w_misaligned      = 1'b0;
  assign misalign_err      = 1'b0;
  assign w_unused_tgt_lsbs = ^br_target[1:0];
`endif

  // The buffer may be refilled when it is empty or being consumed this cycle.
  assign w_capture = !r_if_valid || id_ready;

  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign halted    = r_halted;

  // Fetch state machine: redirect beats halt detection beats capture/stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'h0;
      r_if_pc    <= 8'h00;
      r_halted   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // One settling cycle; redirects are not accepted yet.
          r_state  <= S_RUN;
          r_halted <= 1'b0;
        end

        S_RUN, S_HALT: begin
          if (br_taken) begin
            r_if_valid <= 1'b0;
            if (w_misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
              r_misalign_err <= 1'b1;
`endif
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc     <= w_redirect_pc;
              r_state  <= S_RUN;
              r_halted <= 1'b0;
            end
          end else if (r_state == S_RUN && w_capture) begin
            if (imem_rdata == HALT_WORD) begin
              // Halt word is never handed to decode and pc stays on it.
              r_if_valid <= 1'b0;
              r_state    <= S_HALT;
              r_halted   <= 1'b1;
            end else begin
              r_if_instr <= imem_rdata;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              r_pc       <= r_pc + 8'd4;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_if_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl (sequential fetch,
//               stall, redirect, halt, wrap, mid-run reset, alignment).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        halted;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  assign imem_rdata = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE just after reset release.
  task automatic do_reset();
    br_taken  = 1'b0;
    br_target = 8'h00;
    id_ready  = 1'b1;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr, halted, misalign_err} !==
        {1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_vals: got v=%b pc=%h instr=%h addr=%h halt=%b mis=%b expected all zero",
               if_valid, if_pc, if_instr, imem_addr, halted, misalign_err);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    step();
    tests++;
    if ({if_valid, imem_addr} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL idle_no_capture: got v=%b addr=%h expected v=0 addr=00", if_valid, imem_addr);
    end
    step();
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h00, 32'h00700213, 8'h04}) begin
      fails++;
      $display("FAIL seq_0: got v=%b pc=%h instr=%h addr=%h expected 1/00/00700213/04",
               if_valid, if_pc, if_instr, imem_addr);
    end
    step();
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h04, 32'h00200093, 8'h08}) begin
      fails++;
      $display("FAIL seq_4: got v=%b pc=%h instr=%h addr=%h expected 1/04/00200093/08",
               if_valid, if_pc, if_instr, imem_addr);
    end
    step();
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h08, 32'h0010e113, 8'h0C}) begin
      fails++;
      $display("FAIL seq_8: got v=%b pc=%h instr=%h addr=%h expected 1/08/0010e113/0c",
               if_valid, if_pc, if_instr, imem_addr);
    end
  endtask

  task automatic test_idle_branch();
    do_reset();
    br_taken  = 1'b1;
    br_target = 8'h40;
    step();
    br_taken = 1'b0;
    tests++;
    if ({if_valid, imem_addr, halted} !== {1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL idle_branch_ignored: got v=%b addr=%h halt=%b expected 0/00/0",
               if_valid, imem_addr, halted);
    end
  endtask

  // Ends with if_pc=0x10 valid and imem_addr=0x14 (used by test_redirect).
  task automatic test_stall();
    do_reset();
    step();
    step();
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h04, 32'h00200093, 8'h08}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h addr=%h expected 1/04/00200093/08",
                 i, if_valid, if_pc, if_instr, imem_addr);
      end
    end
    id_ready = 1'b1;
    step();
    tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 8'h08, 32'h0010e113}) begin
      fails++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h expected 1/08/0010e113",
               if_valid, if_pc, if_instr);
    end
    step();
    step();
  endtask

  task automatic test_redirect();
    br_taken  = 1'b1;
    br_target = 8'h10;
    step();
    br_taken = 1'b0;
    tests++;
    if ({if_valid, imem_addr} !== {1'b0, 8'h10}) begin
      fails++;
      $display("FAIL redirect_flush: got v=%b addr=%h expected 0/10", if_valid, imem_addr);
    end
    step();
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'h10, 32'h22222222, 8'h14}) begin
      fails++;
      $display("FAIL redirect_fetch: got v=%b pc=%h instr=%h addr=%h expected 1/10/22222222/14",
               if_valid, if_pc, if_instr, imem_addr);
    end
  endtask

  task automatic test_halt();
    step();
    step();
    tests++;
    if ({halted, if_valid, imem_addr} !== {1'b1, 1'b0, 8'h18}) begin
      fails++;
      $display("FAIL halt_enter: got halt=%b v=%b addr=%h expected 1/0/18", halted, if_valid, imem_addr);
    end
    step();
    step();
    tests++;
    if ({halted, if_valid, imem_addr, if_pc} !== {1'b1, 1'b0, 8'h18, 8'h14}) begin
      fails++;
      $display("FAIL halt_hold: got halt=%b v=%b addr=%h pc=%h expected 1/0/18/14",
               halted, if_valid, imem_addr, if_pc);
    end
    br_taken  = 1'b1;
    br_target = 8'h00;
    step();
    br_taken = 1'b0;
    tests++;
    if ({halted, if_valid, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL halt_exit: got halt=%b v=%b addr=%h expected 0/0/00", halted, if_valid, imem_addr);
    end
    step();
    tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 8'h00, 32'h00700213}) begin
      fails++;
      $display("FAIL halt_resume: got v=%b pc=%h instr=%h expected 1/00/00700213", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap_reset();
    br_taken  = 1'b1;
    br_target = 8'hFC;
    step();
    br_taken = 1'b0;
    step();
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 8'hFC, 32'hA000_003F, 8'h00}) begin
      fails++;
      $display("FAIL wrap: got v=%b pc=%h instr=%h addr=%h expected 1/fc/a000003f/00",
               if_valid, if_pc, if_instr, imem_addr);
    end
    id_ready = 1'b0;
    step();
    step();
    tests++;
    if ({if_valid, if_pc, imem_addr} !== {1'b1, 8'hFC, 8'h00}) begin
      fails++;
      $display("FAIL wrap_stall: got v=%b pc=%h addr=%h expected 1/fc/00", if_valid, if_pc, imem_addr);
    end
    // Reset between clock edges must take effect without waiting for clk.
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({if_valid, if_pc, if_instr, imem_addr, halted, misalign_err} !==
        {1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b pc=%h instr=%h addr=%h halt=%b mis=%b expected all zero",
               if_valid, if_pc, if_instr, imem_addr, halted, misalign_err);
    end
    id_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_align();
    do_reset();
    step();
    step();
    br_taken  = 1'b1;
    br_target = 8'h12;
    step();
    br_taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    tests++;
    if ({misalign_err, halted, if_valid, imem_addr} !== {1'b1, 1'b1, 1'b0, 8'h04}) begin
      fails++;
      $display("FAIL align_err: got mis=%b halt=%b v=%b addr=%h expected 1/1/0/04",
               misalign_err, halted, if_valid, imem_addr);
    end
    step();
    tests++;
    if ({misalign_err, halted, imem_addr} !== {1'b1, 1'b1, 8'h04}) begin
      fails++;
      $display("FAIL align_sticky: got mis=%b halt=%b addr=%h expected 1/1/04", misalign_err, halted, imem_addr);
    end
`else
    tests++;
    if ({misalign_err, halted, if_valid, imem_addr} !== {1'b0, 1'b0, 1'b0, 8'h10}) begin
      fails++;
      $display("FAIL align_down: got mis=%b halt=%b v=%b addr=%h expected 0/0/0/10",
               misalign_err, halted, if_valid, imem_addr);
    end
    step();
    tests++;
    if ({misalign_err, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 8'h10, 32'h22222222}) begin
      fails++;
      $display("FAIL align_fetch: got mis=%b v=%b pc=%h instr=%h expected 0/1/10/22222222",
               misalign_err, if_valid, if_pc, if_instr);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h00700213;
    mem[1] = 32'h00200093;
    mem[2] = 32'h0010e113;
    mem[3] = 32'h11111111;
    mem[4] = 32'h22222222;
    mem[5] = 32'h33333333;
    mem[6] = 32'h00000000;

    test_reset();
    test_sequential();
    test_idle_branch();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_reset();
    test_align();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
